// File: rtl/adc_osr_decimator.sv
// Oversampling decimator: sums 2^k SAR results per frame and emits a left-aligned word over valid/ready.
// Define ADC_OSR_OVERRUN_EN to build the sticky overrun flag; otherwise overrun_out is tied low.
module adc_osr_decimator #(
    parameter int IN_BITS      = 12,
    parameter int MAX_OSR_LOG2 = 4,
    parameter int OUT_BITS     = IN_BITS + MAX_OSR_LOG2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable_in,
    input  logic [2:0]          osr_log2_in,
    input  logic [IN_BITS-1:0]  data_in,
    input  logic                data_valid_in,
    output logic [OUT_BITS-1:0] result_out,
    output logic                result_valid_out,
    input  logic                result_ready_in,
    output logic                overrun_out
);
    localparam int K_W   = $clog2(MAX_OSR_LOG2 + 1);
    localparam int CW    = MAX_OSR_LOG2 + 1;
    localparam int ACC_W = IN_BITS + MAX_OSR_LOG2;

    logic                    valid_d_reg;
    logic [ACC_W-1:0]        acc_reg, acc_next;
    logic [MAX_OSR_LOG2-1:0] cnt_reg, cnt_next;
    logic [K_W-1:0]          k_reg, k_sat, k_eff;
    logic [OUT_BITS-1:0]     result_reg;
    logic                    result_valid_reg;

    logic             accept;
    logic             frame_end;
    logic [CW-1:0]    span_m1;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] shifted;

    always_comb begin
        k_sat = (int'(osr_log2_in) > MAX_OSR_LOG2) ? K_W'(MAX_OSR_LOG2) : K_W'(osr_log2_in);
        // The ratio is sampled only at frame start; mid-frame changes wait for the next frame.
        k_eff     = (cnt_reg == '0) ? k_sat : k_reg;
        accept    = data_valid_in & ~valid_d_reg & enable_in;
        span_m1   = (CW'(1) << k_eff) - CW'(1);
        frame_end = accept && ({1'b0, cnt_reg} == span_m1);
        sum       = acc_reg + ACC_W'(data_in);
        shifted   = sum << (K_W'(MAX_OSR_LOG2) - k_eff);
    end

    always_comb begin
        acc_next = acc_reg;
        cnt_next = cnt_reg;
        if (!enable_in || frame_end) begin
            acc_next = '0;
            cnt_next = '0;
        end else if (accept) begin
            acc_next = sum;
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_d_reg      <= 1'b0;
            acc_reg          <= '0;
            cnt_reg          <= '0;
            k_reg            <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
        end else begin
            valid_d_reg <= data_valid_in;
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            if (cnt_reg == '0)
                k_reg <= k_sat;
            // A new frame result wins over a same-cycle acceptance of the old one.
            if (frame_end) begin
                result_reg       <= shifted;
                result_valid_reg <= 1'b1;
            end else if (result_valid_reg && result_ready_in) begin
                result_valid_reg <= 1'b0;
            end
        end
    end

    assign result_out       = result_reg;
    assign result_valid_out = result_valid_reg;

`ifdef ADC_OSR_OVERRUN_EN
    logic overrun_reg;

    always_ff @(posedge clk) begin
        if (rst)
            overrun_reg <= 1'b0;
        else if (frame_end && result_valid_reg && !result_ready_in)
            overrun_reg <= 1'b1;
    end

    assign overrun_out = overrun_reg;
`else
    assign overrun_out = 1'b0;
`endif

endmodule

// File: tb/tb_adc_osr_decimator.sv
// Bench for adc_osr_decimator: frame vectors from a table plus hand-written corner sequences,
// with expected results queued at stimulus time and popped when the sink accepts a word.
module tb_adc_osr_decimator;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable_in;
    logic [2:0]  osr_log2_in;
    logic [11:0] data_in;
    logic        data_valid_in;
    logic [15:0] result_out;
    logic        result_valid_out;
    logic        result_ready_in;
    logic        overrun_out;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] sb[$];

`ifdef ADC_OSR_OVERRUN_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    adc_osr_decimator dut (
        .clk              (clk),
        .rst              (rst),
        .enable_in        (enable_in),
        .osr_log2_in      (osr_log2_in),
        .data_in          (data_in),
        .data_valid_in    (data_valid_in),
        .result_out       (result_out),
        .result_valid_out (result_valid_out),
        .result_ready_in  (result_ready_in),
        .overrun_out      (overrun_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  osr;
        logic [11:0] base;
        logic [11:0] step;
        int          hold;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Scoreboard side: every word the sink takes must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && result_valid_out && result_ready_in) begin
            if (sb.size() == 0) begin
                check("unexpected_result", {16'd0, result_out}, 32'hffff_ffff);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                check("result", {16'd0, result_out}, {16'd0, e});
                $display("accepted result %0d (expected %0d)", result_out, e);
            end
        end
    end

    task automatic reset_dut();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic drive_sample(input logic [11:0] d, input int hold);
        @(posedge clk); #1;
        data_in       = d;
        data_valid_in = 1'b1;
        repeat (hold) @(posedge clk);
        #1 data_valid_in = 1'b0;
    endtask

    task automatic wait_result(input string name);
        int c = 0;
        result_ready_in = 1'b1;
        while (sb.size() != 0 && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        result_ready_in = 1'b0;
        check({name, "_drain"}, sb.size(), 0);
        check({name, "_valid_cleared"}, {31'd0, result_valid_out}, 0);
    endtask

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ns;
        int ks;
        vecs[0] = '{osr: 3'd0, base: 12'd2048, step: 12'd0,  hold: 1, exp: 16'd32768};
        vecs[1] = '{osr: 3'd4, base: 12'd100,  step: 12'd1,  hold: 1, exp: 16'd1720};
        vecs[2] = '{osr: 3'd1, base: 12'd4095, step: 12'd0,  hold: 3, exp: 16'd65520};
        vecs[3] = '{osr: 3'd2, base: 12'd1000, step: 12'd0,  hold: 2, exp: 16'd16000};
        vecs[4] = '{osr: 3'd3, base: 12'd500,  step: 12'd10, hold: 1, exp: 16'd8560};
        vecs[5] = '{osr: 3'd7, base: 12'd1,    step: 12'd1,  hold: 1, exp: 16'd136};
        vecs[6] = '{osr: 3'd5, base: 12'd4095, step: 12'd0,  hold: 1, exp: 16'd65520};

        rst = 1'b1; enable_in = 1'b1; osr_log2_in = 3'd0; data_in = '0;
        data_valid_in = 1'b0; result_ready_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_result", {16'd0, result_out}, 0);
        check("reset_valid", {31'd0, result_valid_out}, 0);
        check("reset_overrun", {31'd0, overrun_out}, 0);

        for (int v = 0; v < 7; v++) begin
            osr_log2_in = vecs[v].osr;
            ks = (int'(vecs[v].osr) > 4) ? 4 : int'(vecs[v].osr);
            ns = 1 << ks;
            for (int i = 0; i < ns; i++) begin
                if (i == ns - 1) begin
                    check("no_early_valid", {31'd0, result_valid_out}, 0);
                    sb.push_back(vecs[v].exp);
                end
                drive_sample(vecs[v].base + 12'(i) * vecs[v].step, vecs[v].hold);
            end
            check("valid_after_last", {31'd0, result_valid_out}, 1);
            repeat (2) @(posedge clk);
            #1 check("valid_held", {31'd0, result_valid_out}, 1);
            wait_result("vector");
        end

        // Overrun: second result overwrites the unaccepted first one.
        reset_dut();
        osr_log2_in = 3'd0;
        drive_sample(12'd10, 1);
        sb.push_back(16'd320);
        drive_sample(12'd20, 1);
        check("ovr_result", {16'd0, result_out}, 320);
        check("ovr_flag", {31'd0, overrun_out}, {31'd0, EXP_OVR});
        wait_result("overrun");
        check("ovr_sticky", {31'd0, overrun_out}, {31'd0, EXP_OVR});
        reset_dut();
        check("ovr_cleared", {31'd0, overrun_out}, 0);

        // Frame end in the same cycle as acceptance of the previous word: not an overrun.
        sb.push_back(16'd16);
        drive_sample(12'd1, 1);
        sb.push_back(16'd32);
        @(posedge clk); #1;
        data_in = 12'd2; data_valid_in = 1'b1; result_ready_in = 1'b1;
        @(posedge clk); #1 data_valid_in = 1'b0;
        check("simul_valid", {31'd0, result_valid_out}, 1);
        check("simul_no_overrun", {31'd0, overrun_out}, 0);
        wait_result("simul");

        // Abort after two samples, then a new frame with a different ratio.
        osr_log2_in = 3'd2;
        drive_sample(12'd1, 1);
        drive_sample(12'd2, 1);
        @(posedge clk); #1 enable_in = 1'b0;
        @(posedge clk); #1 enable_in = 1'b1;
        osr_log2_in = 3'd1;
        drive_sample(12'd5, 1);
        check("abort_mid", {31'd0, result_valid_out}, 0);
        sb.push_back(16'd96);
        drive_sample(12'd7, 1);
        wait_result("abort");

        // Ratio change mid-frame is ignored.
        drive_sample(12'd30, 1);
        osr_log2_in = 3'd4;
        sb.push_back(16'd560);
        drive_sample(12'd40, 1);
        check("latched_k_valid", {31'd0, result_valid_out}, 1);
        wait_result("latched_k");

        // Strobe rising as enable falls is not accepted.
        osr_log2_in = 3'd0;
        @(posedge clk); #1;
        enable_in = 1'b0; data_in = 12'd77; data_valid_in = 1'b1;
        @(posedge clk); #1 data_valid_in = 1'b0; enable_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("enable_fall_ignored", {31'd0, result_valid_out}, 0);

        // Reset mid-frame with a result pending.
        drive_sample(12'd100, 1);
        osr_log2_in = 3'd4;
        for (int i = 0; i < 5; i++) drive_sample(12'd7, 1);
        reset_dut();
        check("midrst_result", {16'd0, result_out}, 0);
        check("midrst_valid", {31'd0, result_valid_out}, 0);
        check("midrst_overrun", {31'd0, overrun_out}, 0);
        osr_log2_in = 3'd1;
        drive_sample(12'd1, 1);
        sb.push_back(16'd24);
        drive_sample(12'd2, 1);
        check("post_rst_valid", {31'd0, result_valid_out}, 1);
        wait_result("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
